// File: rtl/fir_pkg.sv
// Shared types and constants for the parametrised sequential FIR filter.
// Provides the controller state enum, the accumulator width helper and the
// default parameter values used by the interface and the filter top.
package fir_pkg;

  localparam int DEF_NUM_TAPS     = 4;
  localparam int DEF_DATA_W       = 16;
  localparam int DEF_COEF_W       = 16;
  localparam int DEF_FRAC_BITS    = 15;
  localparam int DEF_SAMPLE_BLOCK = 1000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    MAC   = 3'd3,
    OUT   = 3'd4,
    ERR   = 3'd5
  } fir_state_t;

  // Accumulator must hold NUM_TAPS full-width products without wrapping.
  function automatic int acc_width(input int data_w, input int coef_w, input int num_taps);
    return data_w + coef_w + $clog2(num_taps);
  endfunction

endpackage

// File: rtl/fir_filter_param_if.sv
// Sample/coefficient write port and result port of the FIR filter.
// master: front-end side (drives strobes and data, observes results).
// slave : filter side (consumes strobes and data, drives fir_out/out_valid/modwait/one_k_samples/err).
interface fir_filter_param_if
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W
);

  logic signed [DATA_W-1:0] sample_data;
  logic signed [COEF_W-1:0] fir_coefficient;
  logic                     data_ready;
  logic                     load_coeff;
  logic        [DATA_W-1:0] fir_out;
  logic                     out_valid;
  logic                     modwait;
  logic                     one_k_samples;
  logic                     err;

  modport master (
    output sample_data, fir_coefficient, data_ready, load_coeff,
    input  fir_out, out_valid, modwait, one_k_samples, err
  );

  modport slave (
    input  sample_data, fir_coefficient, data_ready, load_coeff,
    output fir_out, out_valid, modwait, one_k_samples, err
  );

endinterface

// File: rtl/fir_sample_counter.sv
// Counts completed filter outputs and pulses once every SAMPLE_BLOCK of them.
// Latency: pulse is registered, high the cycle after the inc that completes a block.
// Backpressure: none; clr has priority over inc.
// Ports: clk, n_reset (sync, active-low), clr, inc -> pulse.
module fir_sample_counter #(
  parameter int SAMPLE_BLOCK = 1000
) (
  input  logic clk,
  input  logic n_reset,
  input  logic clr,
  input  logic inc,
  output logic pulse
);

  localparam int CNT_W = (SAMPLE_BLOCK > 1) ? $clog2(SAMPLE_BLOCK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_BLOCK - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (inc) begin
        if (cnt == CNT_LAST) begin
          cnt   <= '0;
          pulse <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fir_filter_param.sv
// Sequential FIR: runtime-loaded coefficients, one tap per clock through a single MAC.
// Latency: data_ready accepted in cycle 0 -> out_valid in cycle NUM_TAPS+2.
// Backpressure: modwait high while busy; strobes seen while busy are dropped and flag err.
// Ports: clk, n_reset (sync, active-low), bus (fir_filter_param_if.slave).
// Build option: define FIR_SATURATE_EN to saturate overflowing results instead of flagging err.
module fir_filter_param
  import fir_pkg::*;
#(
  parameter int NUM_TAPS     = DEF_NUM_TAPS,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int COEF_W       = DEF_COEF_W,
  parameter int FRAC_BITS    = DEF_FRAC_BITS,
  parameter int SAMPLE_BLOCK = DEF_SAMPLE_BLOCK
) (
  input  logic               clk,
  input  logic               n_reset,
  fir_filter_param_if.slave  bus
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, NUM_TAPS);
  localparam int IDX_W  = $clog2(NUM_TAPS);
  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NUM_TAPS - 1);

  fir_state_t state, state_nxt;

  logic signed [DATA_W-1:0] x_line [NUM_TAPS];
  logic signed [COEF_W-1:0] coef   [NUM_TAPS];
  logic        [IDX_W-1:0]  coef_idx;
  logic        [IDX_W-1:0]  tap;
  logic                     coeffs_valid;
  logic signed [ACC_W-1:0]  acc;
  logic        [DATA_W-1:0] fir_out_q;
  logic                     ovf_q;
  logic                     pend_err;

  logic                     strobe;
  logic                     busy;
  logic                     load_acc;
  logic                     smp_acc;
  logic                     last_mac;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  res;
  logic        [ACC_W-1:DATA_W] res_hi;
  logic        [DATA_W:0]   res_lo;
  logic        [DATA_W:0]   mag;
  logic                     ovf;
  logic                     ovf_flag;
  logic        [DATA_W-1:0] res_out;

  assign strobe = bus.data_ready | bus.load_coeff;

  // ---------------- controller ----------------
  always_ff @(posedge clk) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    load_acc  = 1'b0;
    smp_acc   = 1'b0;
    last_mac  = 1'b0;
    case (state)
      IDLE, ERR: begin
        // A coefficient write beats a simultaneous sample.
        if (bus.load_coeff) begin
          state_nxt = LOAD;
          load_acc  = 1'b1;
        end else if (bus.data_ready) begin
          if (coeffs_valid) begin
            state_nxt = SHIFT;
            smp_acc   = 1'b1;
          end else begin
            state_nxt = ERR;
          end
        end
      end
      LOAD: begin
        busy      = 1'b1;
        state_nxt = (pend_err | strobe) ? ERR : IDLE;
      end
      SHIFT: begin
        busy      = 1'b1;
        state_nxt = MAC;
      end
      MAC: begin
        busy = 1'b1;
        if (tap == LAST_TAP) begin
          last_mac  = 1'b1;
          state_nxt = OUT;
        end
      end
      OUT: begin
        busy      = 1'b1;
        state_nxt = (pend_err | strobe | ovf_q) ? ERR : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Remembers a rejected strobe until the running operation finishes.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      pend_err <= 1'b0;
    end else if (state_nxt == IDLE || state_nxt == ERR) begin
      pend_err <= 1'b0;
    end else if ((busy && strobe) || (load_acc && bus.data_ready)) begin
      pend_err <= 1'b1;
    end
  end

  // ---------------- coefficient bank and delay line ----------------
  // Both are written at the accepting edge so the strobes may be single-cycle.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        coef[i]   <= '0;
        x_line[i] <= '0;
      end
      coef_idx     <= '0;
      coeffs_valid <= 1'b0;
    end else begin
      if (load_acc) begin
        coef[coef_idx] <= bus.fir_coefficient;
        if (coef_idx == LAST_TAP) begin
          coef_idx     <= '0;
          coeffs_valid <= 1'b1;
        end else begin
          coef_idx <= coef_idx + IDX_W'(1);
        end
      end
      if (smp_acc) begin
        x_line[0] <= bus.sample_data;
        for (int i = 1; i < NUM_TAPS; i++) x_line[i] <= x_line[i-1];
      end
    end
  end

  // ---------------- MAC and result formatting ----------------
  assign prod    = coef[tap] * x_line[tap];
  assign acc_sum = acc + ACC_W'(prod);
  assign res     = acc_sum >>> FRAC_BITS;

  // Fits in DATA_W+1 signed bits only if all bits above DATA_W equal the sign.
  assign res_hi = res[ACC_W-1:DATA_W];
  assign ovf    = ~((&res_hi) | ~(|res_hi));

  // Magnitude modulo 2^(DATA_W+1): enough for in-range values and for the
  // low-bits wrap on overflow.
  assign res_lo = res[DATA_W:0];
  assign mag    = res[ACC_W-1] ? -res_lo : res_lo;

`ifdef FIR_SATURATE_EN
  assign res_out  = (ovf || mag[DATA_W]) ? {DATA_W{1'b1}} : mag[DATA_W-1:0];
  assign ovf_flag = 1'b0;
`else
  assign res_out  = (!ovf && mag[DATA_W]) ? {DATA_W{1'b1}} : mag[DATA_W-1:0];
  assign ovf_flag = ovf;
`endif

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      acc       <= '0;
      tap       <= '0;
      fir_out_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (state == SHIFT) begin
        acc <= '0;
        tap <= '0;
      end else if (state == MAC) begin
        acc <= acc_sum;
        tap <= last_mac ? '0 : tap + IDX_W'(1);
      end
      // Result registered on the final tap so it is visible during OUT.
      if (last_mac) begin
        fir_out_q <= res_out;
        ovf_q     <= ovf_flag;
      end
    end
  end

  fir_sample_counter #(
    .SAMPLE_BLOCK(SAMPLE_BLOCK)
  ) u_sample_counter (
    .clk     (clk),
    .n_reset (n_reset),
    .clr     (load_acc && (coef_idx == LAST_TAP)),
    .inc     (last_mac),
    .pulse   (bus.one_k_samples)
  );

  assign bus.fir_out   = fir_out_q;
  assign bus.out_valid = (state == OUT);
  assign bus.modwait   = busy;
  assign bus.err       = (state == ERR);

endmodule

// File: tb/tb_fir_filter_param.sv
// Bench for fir_filter_param: directed scenarios with literal expectations, then
// randomized strobes/resets, all outputs compared every cycle to a cycle-count model.
// Built with NUM_TAPS=4, FRAC_BITS=0, SAMPLE_BLOCK=4; honours FIR_SATURATE_EN.
module tb_fir_filter_param;

  localparam int NT  = 4;
  localparam int DW  = 16;
  localparam int CW  = 16;
  localparam int FB  = 0;
  localparam int BLK = 4;

  logic clk;
  logic n_reset;
  int   total = 0;
  int   bad   = 0;

  fir_filter_param_if #(.DATA_W(DW), .COEF_W(CW)) ifc ();

  fir_filter_param #(
    .NUM_TAPS(NT), .DATA_W(DW), .COEF_W(CW), .FRAC_BITS(FB), .SAMPLE_BLOCK(BLK)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks how many busy cycles remain instead of any state encoding.
  int          m_coef [NT];
  int          m_x    [NT];
  int          m_idx, m_cnt, m_busy;
  bit          m_valid, m_pend, m_is_smp, m_ovf_err, m_err, m_ov_pulse, m_one_k, started;
  logic [15:0] m_out, m_res;

  function automatic void predict(output logic [15:0] o, output bit ov);
    longint s, r, m;
    s = 0;
    for (int k = 0; k < NT; k++) s += longint'(m_coef[k]) * longint'(m_x[k]);
    r  = s >>> FB;
    ov = (r > 65535) || (r < -65536);
    m  = (r < 0) ? -r : r;
`ifdef FIR_SATURATE_EN
    o = (ov || m == 65536) ? 16'hFFFF : m[15:0];
`else
    o = (!ov && m == 65536) ? 16'hFFFF : m[15:0];
`endif
  endfunction

  always @(posedge clk) begin : model
    logic [15:0] o;
    bit          ov;
    m_ov_pulse = 0;
    m_one_k    = 0;
    if (!n_reset) begin
      for (int k = 0; k < NT; k++) begin m_coef[k] = 0; m_x[k] = 0; end
      m_idx = 0; m_cnt = 0; m_busy = 0; m_valid = 0; m_pend = 0;
      m_is_smp = 0; m_ovf_err = 0; m_err = 0; m_out = '0; m_res = '0;
      started = 1;
    end else if (started) begin
      if (m_busy != 0) begin
        if (ifc.data_ready || ifc.load_coeff) m_pend = 1;
        m_busy--;
        if (m_busy == 1 && m_is_smp) begin
          m_ov_pulse = 1;
          m_out      = m_res;
          if (m_ovf_err) m_pend = 1;
          m_cnt++;
          if (m_cnt == BLK) begin m_cnt = 0; m_one_k = 1; end
        end
        if (m_busy == 0) begin m_err = m_pend; m_pend = 0; end
      end else if (ifc.load_coeff) begin
        m_coef[m_idx] = int'(ifc.fir_coefficient);
        m_err = 0; m_busy = 1; m_is_smp = 0; m_pend = ifc.data_ready;
        if (m_idx == NT - 1) begin m_idx = 0; m_valid = 1; m_cnt = 0; end
        else m_idx++;
      end else if (ifc.data_ready) begin
        if (m_valid) begin
          for (int k = NT - 1; k > 0; k--) m_x[k] = m_x[k-1];
          m_x[0] = int'(ifc.sample_data);
          predict(o, ov);
          m_res = o;
`ifdef FIR_SATURATE_EN
          m_ovf_err = 0;
`else
          m_ovf_err = ov;
`endif
          m_busy = NT + 2; m_is_smp = 1; m_err = 0;
        end else begin
          m_err = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("fir_out",   32'(ifc.fir_out),       32'(m_out));
      check("out_valid", 32'(ifc.out_valid),     32'(m_ov_pulse));
      check("modwait",   32'(ifc.modwait),       32'(m_busy != 0));
      check("err",       32'(ifc.err),           32'(m_err));
      check("one_k",     32'(ifc.one_k_samples), 32'(m_one_k));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_free();
    int n = 0;
    while (ifc.modwait !== 1'b0 && n < 50) begin tick(); n++; end
    check("wait_free", 32'(ifc.modwait), 32'd0);
  endtask

  task automatic load(input logic [15:0] c);
    ifc.fir_coefficient = c;
    ifc.load_coeff = 1'b1;
    tick();
    ifc.load_coeff = 1'b0;
    wait_free();
  endtask

  task automatic send_sample(input logic [15:0] d);
    ifc.sample_data = d;
    ifc.data_ready  = 1'b1;
    tick();
    ifc.data_ready  = 1'b0;
  endtask

  // Called in the cycle after the accepting edge, so that cycle counts as 1.
  task automatic wait_out(output int lat);
    lat = 1;
    while (ifc.out_valid !== 1'b1 && lat < 30) begin tick(); lat++; end
  endtask

  task automatic do_reset();
    n_reset = 1'b0;
    tick();
    n_reset = 1'b1;
  endtask

  initial begin
    int lat, pulses, onek4, nvalid, r;
    n_reset = 1'b0;
    ifc.sample_data = '0; ifc.fir_coefficient = '0;
    ifc.data_ready = 1'b0; ifc.load_coeff = 1'b0;
    tick(); tick();
    check("rst_fir_out", 32'(ifc.fir_out), 32'd0);
    check("rst_modwait", 32'(ifc.modwait), 32'd0);
    check("rst_err",     32'(ifc.err),     32'd0);
    n_reset = 1'b1;
    tick();

    // coefficients 1,2,3,4; samples 10 then 20
    load(16'd1); load(16'd2); load(16'd3); load(16'd4);
    send_sample(16'd10); wait_out(lat);
    check("lat_a", 32'(lat), 32'd6);
    check("out_a", 32'(ifc.fir_out), 32'd10);
    wait_free();
    send_sample(16'd20); wait_out(lat);
    check("lat_b", 32'(lat), 32'd6);
    check("out_b", 32'(ifc.fir_out), 32'd40);
    wait_free();

    // negative sample magnitude
    load(16'd1); load(16'd0); load(16'd0); load(16'd0);
    send_sample(16'hFFFB); wait_out(lat);
    check("neg_out", 32'(ifc.fir_out), 32'd5);
    wait_free();
    check("neg_err", 32'(ifc.err), 32'd0);

    // full-scale overflow
    for (int i = 0; i < 4; i++) load(16'h7FFF);
    for (int i = 0; i < 4; i++) begin
      send_sample(16'h7FFF); wait_out(lat); tick(); wait_free();
    end
`ifdef FIR_SATURATE_EN
    check("ovf_out", 32'(ifc.fir_out), 32'hFFFF);
    check("ovf_err", 32'(ifc.err), 32'd0);
`else
    check("ovf_out", 32'(ifc.fir_out), 32'h0004);
    check("ovf_err", 32'(ifc.err), 32'd1);
`endif

    // sample strobe during MAC is dropped and flagged after OUT
    load(16'd1); load(16'd0); load(16'd0); load(16'd0);
    send_sample(16'd7);
    tick();
    ifc.sample_data = 16'd99; ifc.data_ready = 1'b1;
    tick();
    ifc.data_ready = 1'b0;
    wait_out(lat);
    check("busy_out", 32'(ifc.fir_out), 32'd7);
    tick();
    check("busy_err", 32'(ifc.err), 32'd1);
    check("busy_mw",  32'(ifc.modwait), 32'd0);
    send_sample(16'd9);
    check("clr_err", 32'(ifc.err), 32'd0);
    wait_out(lat);
    check("clr_out", 32'(ifc.fir_out), 32'd9);
    wait_free();

    // sample before the bank is complete, then block pulse
    do_reset();
    load(16'd1); load(16'd1); load(16'd1);
    send_sample(16'd5);
    check("nocoef_err", 32'(ifc.err), 32'd1);
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin nvalid += int'(ifc.out_valid); tick(); end
    check("nocoef_nv", 32'(nvalid), 32'd0);
    load(16'd1);
    pulses = 0; onek4 = 0;
    for (int i = 1; i <= 4; i++) begin
      send_sample(16'(i)); wait_out(lat);
      pulses += int'(ifc.one_k_samples);
      if (i == 4) onek4 = int'(ifc.one_k_samples);
      wait_free();
    end
    check("blk_pulses", 32'(pulses), 32'd1);
    check("blk_4th",    32'(onek4),  32'd1);
    check("blk_out",    32'(ifc.fir_out), 32'd10);

    // reset in the middle of MAC
    send_sample(16'd5);
    tick(); tick();
    do_reset();
    check("mrst_out", 32'(ifc.fir_out),   32'd0);
    check("mrst_mw",  32'(ifc.modwait),   32'd0);
    check("mrst_err", 32'(ifc.err),       32'd0);
    check("mrst_ov",  32'(ifc.out_valid), 32'd0);
    send_sample(16'd3);
    check("mrst_nocoef", 32'(ifc.err), 32'd1);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 199));
      n_reset        = (r != 0);
      ifc.load_coeff = (r >= 1 && r < 16) || (r >= 190);
      ifc.data_ready = (r >= 16 && r < 70) || (r >= 190);
      ifc.fir_coefficient = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                        : 16'($urandom_range(0, 127)) - 16'd64;
      ifc.sample_data     = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                        : 16'($urandom_range(0, 2047)) - 16'd1024;
      tick();
    end
    n_reset = 1'b1; ifc.load_coeff = 1'b0; ifc.data_ready = 1'b0;
    repeat (10) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
